pc_gen: RTL
===========

PC_GEN -- requirements
Module: pc_gen

Interface
- REQ-001: Parameter PC_W, default 32, PC width in bits (16..64).
- REQ-002: Parameter RESET_VEC, default 0, PC value loaded on reset (PC_W bits).
- REQ-003: Parameter INC, default 4, sequential PC increment.
- REQ-004: Parameter RAS_DEPTH, default 4, return-address-stack entries (power of 2, 2..16).
- REQ-005: CLK  in  1  clock; all state updates on rising edge.
- REQ-006: RESET  in  1  reset, synchronous, active-high.
- REQ-007: STALL  in  1  hold PC and RAS this cycle.
- REQ-008: FLUSH  in  1  redirect to FLUSH_TGT (trap/mispredict).
- REQ-009: FLUSH_TGT  in  PC_W  flush target.
- REQ-010: BR_TAKEN  in  1  taken branch/jump; next PC = BR_TGT.
- REQ-011: BR_TGT  in  PC_W  branch/jump target.
- REQ-012: CALL  in  1  with BR_TAKEN, push PC_OUT+INC onto RAS.
- REQ-013: RET  in  1  next PC = RAS top; pop.
- REQ-014: PC_OUT  out  PC_W  current PC, registered.
- REQ-015: RAS_EMPTY  out  1  RAS holds 0 entries, registered.
- REQ-016: RAS_UFLOW  out  1  one-cycle pulse: RET on empty RAS.
- REQ-017: MISALIGN  out  1  one-cycle pulse: misaligned redirect (see Configuration).

Function
- REQ-018: Next-PC priority, highest first: RESET, FLUSH, STALL, RET, BR_TAKEN, sequential (PC_OUT+INC).
- REQ-019: All PC updates take effect the cycle after the qualifying input; latency 1 cycle, no combinational input-to-PC_OUT path.
- REQ-020: Sequential and target arithmetic modulo 2^PC_W; PC_OUT+INC wraps from all-ones region to low addresses without flag.
- REQ-021: FLUSH overrides STALL, RET, CALL, BR_TAKEN; RAS unchanged on FLUSH.
- REQ-022: STALL (without FLUSH) holds PC_OUT and RAS; CALL/RET/BR_TAKEN ignored that cycle.
- REQ-023: CALL without BR_TAKEN is ignored.
- REQ-024: CALL push when RAS full overwrites oldest entry (circular); count saturates at RAS_DEPTH.
- REQ-025: RET with RAS non-empty: next PC = top entry, count decrements.
- REQ-026: RET with RAS empty: next PC = PC_OUT+INC, RAS_UFLOW pulses 1 cycle, count stays 0.
- REQ-027: RET and CALL+BR_TAKEN same cycle: next PC = top entry (RET priority); top replaced by PC_OUT+INC, count unchanged; on empty RAS, push occurs and RAS_UFLOW pulses.
- REQ-028: RAS_EMPTY and RAS_UFLOW are registered, reflecting state after the edge.

Reset
- REQ-029: RESET synchronous, active-high, dominates all inputs.
- REQ-030: On reset: PC_OUT=RESET_VEC, RAS count=0, RAS_EMPTY=1, RAS_UFLOW=0, MISALIGN=0; RAS entry contents don't-care.
- REQ-031: Reset mid-sequence (during STALL, FLUSH, RET) discards pending redirect; first post-reset PC is RESET_VEC, then RESET_VEC+INC.

Configuration
- REQ-032: Macro PC_GEN_MISALIGN_CHECK_EN.
- REQ-033: Defined: any redirect (FLUSH_TGT, BR_TGT, RAS pop) with bits [1:0] != 0 loads target with bits [1:0] cleared and pulses MISALIGN one cycle.
- REQ-034: Undefined: targets loaded unmodified; MISALIGN tied 0; no check logic synthesised.

Verification
- REQ-035: RESET 1 cycle, then 3 idle cycles -> PC_OUT 0x0, 0x4, 0x8, 0xC.
- REQ-036: At PC=0x10 BR_TAKEN+CALL BR_TGT=0x100; later at PC=0x108 RET -> PC 0x100, then 0x14; RAS_EMPTY 1 after RET.
- REQ-037: RET at reset (empty) with PC=0x0 -> PC 0x4, RAS_UFLOW 1 for exactly 1 cycle.
- REQ-038: STALL+BR_TAKEN at PC=0x20 -> PC stays 0x20; FLUSH+STALL FLUSH_TGT=0x80 -> PC 0x80.
- REQ-039: RAS_DEPTH=4: 5 CALLs pushing 0x4,0x8,0xC,0x10,0x14 then 5 RETs -> 0x14,0x10,0xC,0x8, then PC+INC with RAS_UFLOW pulse.
- REQ-040: PC_W=32 at PC=0xFFFFFFFC idle -> PC 0x0; with PC_GEN_MISALIGN_CHECK_EN, BR_TGT=0x103 -> PC 0x100, MISALIGN 1 cycle.

Source files
------------

// File: rtl/pc_gen.sv
// Next-PC generator with a circular return-address stack.
// Define PC_GEN_MISALIGN_CHECK_EN to word-align redirect targets and flag them.
module pc_gen #(
  parameter int              PC_W      = 32,
  parameter logic [PC_W-1:0] RESET_VEC = '0,
  parameter int              INC       = 4,
  parameter int              RAS_DEPTH = 4
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            STALL,
  input  logic            FLUSH,
  input  logic [PC_W-1:0] FLUSH_TGT,
  input  logic            BR_TAKEN,
  input  logic [PC_W-1:0] BR_TGT,
  input  logic            CALL,
  input  logic            RET,
  output logic [PC_W-1:0] PC_OUT,
  output logic            RAS_EMPTY,
  output logic            RAS_UFLOW,
  output logic            MISALIGN
);

  localparam int AW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam logic [PC_W-1:0] INC_V = PC_W'(INC);
  localparam logic [CW-1:0]   FULL  = CW'(RAS_DEPTH);

  logic [PC_W-1:0] ras [RAS_DEPTH];
  logic [AW-1:0]   sp;
  logic [CW-1:0]   cnt;

  logic [PC_W-1:0] seq;
  logic [PC_W-1:0] tgt;
  logic [PC_W-1:0] tgt_al;
  logic [PC_W-1:0] nxt_pc;
  logic [AW-1:0]   top_idx;
  logic [AW-1:0]   wr_idx;
  logic [AW-1:0]   sp_nxt;
  logic [CW-1:0]   cnt_nxt;
  logic            has;
  logic            call_br;
  logic            pop;
  logic            push;
  logic            repl;
  logic            redir;
  logic            uflow_c;
  logic            mis_c;
  logic            act;

  always_comb begin
    seq     = PC_OUT + INC_V;
    top_idx = sp - 1'b1;
    has     = (cnt != '0);
    call_br = CALL & BR_TAKEN;
    pop     = RET & has;
    uflow_c = RET & ~has;
    act     = ~FLUSH & ~STALL;
    redir   = 1'b0;
    tgt     = seq;
    if (FLUSH) begin
      redir = 1'b1;
      tgt   = FLUSH_TGT;
    end else if (RET) begin
      if (has) begin
        redir = 1'b1;
        tgt   = ras[top_idx];
      end
    end else if (BR_TAKEN) begin
      redir = 1'b1;
      tgt   = BR_TGT;
    end
  end

`ifdef PC_GEN_MISALIGN_CHECK_EN
  always_comb begin
    mis_c  = redir & (tgt[1:0] != 2'b00);
    tgt_al = {tgt[PC_W-1:2], 2'b00};
  end
`else
  always_comb begin
    mis_c  = 1'b0;
    tgt_al = tgt;
  end
`endif

  // A call paired with a pop rewrites the top slot instead of pushing.
  always_comb begin
    nxt_pc  = redir ? tgt_al : seq;
    push    = call_br & ~pop;
    repl    = call_br & pop;
    wr_idx  = repl ? top_idx : sp;
    sp_nxt  = sp;
    cnt_nxt = cnt;
    if (push) begin
      sp_nxt  = sp + 1'b1;
      cnt_nxt = (cnt == FULL) ? cnt : cnt + 1'b1;
    end else if (pop && !call_br) begin
      sp_nxt  = top_idx;
      cnt_nxt = cnt - 1'b1;
    end
  end

  logic mis_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      PC_OUT    <= RESET_VEC;
      sp        <= '0;
      cnt       <= '0;
      RAS_EMPTY <= 1'b1;
      RAS_UFLOW <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      RAS_UFLOW <= 1'b0;
      mis_q     <= 1'b0;
      if (FLUSH) begin
        PC_OUT <= nxt_pc;
        mis_q  <= mis_c;
      end else if (!STALL) begin
        PC_OUT    <= nxt_pc;
        sp        <= sp_nxt;
        cnt       <= cnt_nxt;
        RAS_EMPTY <= (cnt_nxt == '0);
        RAS_UFLOW <= uflow_c;
        mis_q     <= mis_c;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET && act && call_br) ras[wr_idx] <= seq;
  end

`ifdef PC_GEN_MISALIGN_CHECK_EN
  assign MISALIGN = mis_q;
`else
  assign MISALIGN = 1'b0;
`endif

endmodule
